// File: rtl/legv8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | legv8_pkg : shared constants and types for the LEGv8 register file |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package legv8_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int XZR_IDX  = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/legv8_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | legv8_scoreboard : pending-write busy vector with two lookups      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module legv8_scoreboard #(
  parameter int ADDR_W   = legv8_pkg::ADDR_W,
  parameter int NUM_REGS = legv8_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              busy1,
  output logic              busy2
);

  // The top entry is XZR and never holds a pending producer.
  logic [NUM_REGS-2:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (issue_valid && (issue_reg == i[ADDR_W-1:0])) begin
          r_busy[i] <= 1'b1;
        end else if (reg_write && (write_reg == i[ADDR_W-1:0])) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign w_busy_vec = {1'b0, r_busy};
  assign busy1      = w_busy_vec[read_reg1];
  assign busy2      = w_busy_vec[read_reg2];

endmodule
`default_nettype wire

// File: rtl/legv8_regfile_wb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | legv8_regfile_wb : LEGv8 register file, write-back port, scoreboard |
// | Optional macro REGFILE_WB_BYPASS_EN enables write-first forwarding. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module legv8_regfile_wb #(
  parameter int DATA_W   = legv8_pkg::DATA_W,
  parameter int ADDR_W   = legv8_pkg::ADDR_W,
  parameter int NUM_REGS = legv8_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard
);

  import legv8_pkg::*;

  localparam logic [ADDR_W-1:0] c_xzr = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_sb_busy1;
  logic              w_sb_busy2;
  logic              w_wr_en;

  assign w_wr_en = reg_write && (write_reg != c_xzr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  legv8_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .reg_write   (w_wr_en),
    .write_reg   (write_reg),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .busy1       (w_sb_busy1),
    .busy2       (w_sb_busy2)
  );

`ifdef REGFILE_WB_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;
  logic w_reissue;

  // A same-cycle reissue of the written register keeps it pending.
  assign w_fwd1    = w_wr_en && (write_reg == read_reg1);
  assign w_fwd2    = w_wr_en && (write_reg == read_reg2);
  assign w_reissue = issue_valid && (issue_reg == write_reg);

  assign read_data1 = (read_reg1 == c_xzr) ? '0 : (w_fwd1 ? write_data : r_regs[read_reg1]);
  assign read_data2 = (read_reg2 == c_xzr) ? '0 : (w_fwd2 ? write_data : r_regs[read_reg2]);
  assign busy1      = w_sb_busy1 && !(w_fwd1 && !w_reissue);
  assign busy2      = w_sb_busy2 && !(w_fwd2 && !w_reissue);
`else
  assign read_data1 = (read_reg1 == c_xzr) ? '0 : r_regs[read_reg1];
  assign read_data2 = (read_reg2 == c_xzr) ? '0 : r_regs[read_reg2];
  assign busy1      = w_sb_busy1;
  assign busy2      = w_sb_busy2;
`endif

  assign hazard = busy1 | busy2;

endmodule
`default_nettype wire

// File: tb/tb_legv8_regfile_wb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_legv8_regfile_wb : table, directed and random checks            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_legv8_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg, issue_reg;
  logic [63:0] read_data1, read_data2, write_data;
  logic        reg_write, issue_valid;
  logic        busy1, busy2, hazard;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_mem  [32];
  logic        m_busy [32];

  typedef struct {
    logic        rst;
    logic [4:0]  rr1, rr2;
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [63:0] d1, d2;
    logic        b1, b2;
  } vec_t;

  vec_t tbl [17];

  legv8_regfile_wb dut (
    .clk         (clk),
    .reset       (reset),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .busy1       (busy1),
    .busy2       (busy2),
    .hazard      (hazard)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [4:0] rr1, logic [4:0] rr2, logic rw,
                              logic [4:0] wr, logic [63:0] wd, logic iv, logic [4:0] ir,
                              logic [63:0] d1, logic [63:0] d2, logic b1, logic b2);
    vec_t v;
    v.rst = rst; v.rr1 = rr1; v.rr2 = rr2; v.rw = rw; v.wr = wr; v.wd = wd;
    v.iv = iv; v.ir = ir; v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge.
  task automatic apply(input logic rst, input logic [4:0] rr1, input logic [4:0] rr2,
                       input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                       input logic iv, input logic [4:0] ir);
    reset = rst; read_reg1 = rr1; read_reg2 = rr2; reg_write = rw;
    write_reg = wr; write_data = wd; issue_valid = iv; issue_reg = ir;
    @(negedge clk);
  endtask

  // Reference model advances at the edge using the architectural rules.
  task automatic finish_cycle();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      if (reg_write && write_reg != 5'd31) begin
        m_mem[write_reg] = write_data;
        m_busy[write_reg] = 1'b0;
      end
      if (issue_valid && issue_reg != 5'd31) m_busy[issue_reg] = 1'b1;
    end
    #1;
  endtask

  function automatic logic fwd(input logic [4:0] rr);
`ifdef REGFILE_WB_BYPASS_EN
    return reg_write && write_reg != 5'd31 && write_reg == rr;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] exp_data(input logic [4:0] rr);
    if (rr == 5'd31) return '0;
    if (fwd(rr)) return write_data;
    return m_mem[rr];
  endfunction

  function automatic logic exp_busy(input logic [4:0] rr);
    if (rr == 5'd31) return 1'b0;
    if (fwd(rr) && !(issue_valid && issue_reg == write_reg)) return 1'b0;
    return m_busy[rr];
  endfunction

  task automatic chk_model();
    logic eb1, eb2;
    eb1 = exp_busy(read_reg1);
    eb2 = exp_busy(read_reg2);
    chk("rnd_data1", read_data1, exp_data(read_reg1));
    chk("rnd_data2", read_data2, exp_data(read_reg2));
    chk("rnd_busy1", {63'd0, busy1}, {63'd0, eb1});
    chk("rnd_busy2", {63'd0, busy2}, {63'd0, eb2});
    chk("rnd_hazard", {63'd0, hazard}, {63'd0, eb1 | eb2});
  endtask

  function automatic logic [4:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end

    //         rst rr1 rr2 rw wr  wd                      iv ir   d1               d2               b1 b2
    tbl[0]  = mk(1, 5, 31, 0, 0,  64'h0,                  0, 0,   64'h0,           64'h0,           0, 0);
    tbl[1]  = mk(1, 5, 31, 0, 0,  64'h0,                  0, 0,   64'h0,           64'h0,           0, 0);
    tbl[2]  = mk(0, 5, 31, 1, 3,  64'h0000_0000_DEAD_BEEF,0, 0,   64'h0,           64'h0,           0, 0);
    tbl[3]  = mk(0, 0, 3,  0, 0,  64'h0,                  0, 0,   64'h0,           64'hDEADBEEF,    0, 0);
    tbl[4]  = mk(0, 31, 3, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF,1, 31,  64'h0,           64'hDEADBEEF,    0, 0);
    tbl[5]  = mk(0, 31, 31,0, 0,  64'h0,                  1, 7,   64'h0,           64'h0,           0, 0);
    tbl[6]  = mk(0, 7, 3,  1, 7,  64'd42,                 0, 0,   64'h0,           64'hDEADBEEF,    1, 0);
    tbl[7]  = mk(0, 7, 7,  0, 0,  64'h0,                  0, 0,   64'd42,          64'd42,          0, 0);
    tbl[8]  = mk(0, 9, 31, 0, 0,  64'h0,                  1, 9,   64'h0,           64'h0,           0, 0);
    tbl[9]  = mk(0, 9, 9,  1, 9,  64'd1,                  1, 9,   64'h0,           64'h0,           1, 1);
    tbl[10] = mk(0, 9, 0,  1, 9,  64'd2,                  0, 0,   64'd1,           64'h0,           1, 0);
    tbl[11] = mk(0, 9, 9,  0, 0,  64'h0,                  0, 0,   64'd2,           64'd2,           0, 0);
    tbl[12] = mk(0, 3, 0,  1, 4,  64'd10,                 1, 4,   64'hDEADBEEF,    64'h0,           0, 0);
    tbl[13] = mk(0, 4, 6,  0, 0,  64'h0,                  1, 6,   64'd10,          64'h0,           1, 0);
    tbl[14] = mk(1, 4, 6,  1, 4,  64'd99,                 1, 5,   64'd10,          64'h0,           1, 1);
    tbl[15] = mk(0, 4, 6,  0, 0,  64'h0,                  0, 0,   64'h0,           64'h0,           0, 0);
    tbl[16] = mk(0, 3, 7,  0, 0,  64'h0,                  0, 0,   64'h0,           64'h0,           0, 0);

    reset = 1'b1; read_reg1 = '0; read_reg2 = '0; reg_write = 1'b0;
    write_reg = '0; write_data = '0; issue_valid = 1'b0; issue_reg = '0;
    @(posedge clk); #1;
    finish_cycle();

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rst, tbl[i].rr1, tbl[i].rr2, tbl[i].rw, tbl[i].wr, tbl[i].wd, tbl[i].iv, tbl[i].ir);
`ifdef REGFILE_WB_BYPASS_EN
      chk_model();
`else
      chk($sformatf("tbl%0d_data1", i), read_data1, tbl[i].d1);
      chk($sformatf("tbl%0d_data2", i), read_data2, tbl[i].d2);
      chk($sformatf("tbl%0d_busy1", i), {63'd0, busy1}, {63'd0, tbl[i].b1});
      chk($sformatf("tbl%0d_busy2", i), {63'd0, busy2}, {63'd0, tbl[i].b2});
      chk($sformatf("tbl%0d_hazard", i), {63'd0, hazard}, {63'd0, tbl[i].b1 | tbl[i].b2});
`endif
      finish_cycle();
    end

    // Write-cycle visibility of X12, then the value one cycle later.
    apply(0, 12, 12, 1, 12, 64'h55, 0, 0);
`ifdef REGFILE_WB_BYPASS_EN
    chk("wr_cycle_data", read_data1, 64'h55);
`else
    chk("wr_cycle_data", read_data1, 64'h0);
`endif
    finish_cycle();
    apply(0, 12, 31, 0, 0, 64'h0, 0, 0);
    chk("wr_next_data", read_data1, 64'h55);
    chk("wr_next_xzr", read_data2, 64'h0);
    finish_cycle();

    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 49) == 0), rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)),
            rnd_addr(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), rnd_addr());
      chk_model();
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
